// File: rtl/sysbus_mem_responder.sv
// Memory-side responder on the multiplexed system bus: ALE address latch, base decode,
// wait-stated read/write to an internal word array. Optional macro SYSBUS_AUTOINC_EN.
module sysbus_mem_responder #(
  parameter int                DATA_W      = 16,
  parameter int                DEPTH_LOG2  = 8,
  parameter logic [DATA_W-1:0] BASE_ADDR   = 16'h0000,
  parameter int                WAIT_STATES = 1
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic [DATA_W-1:0] AdIn,
  input  logic              ALE,
  input  logic              nME,
  input  logic              nOE,
  input  logic              nWE,
  output logic [DATA_W-1:0] DataOut,
  output logic              DataOe,
  output logic              Ready,
  output logic              Sel
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_WAIT   = 3'd2,
    S_RDRIVE = 3'd3,
    S_WDONE  = 3'd4
  } state_e;

`ifdef SYSBUS_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  // Only the index is kept: the upper address bits matter solely for the decode held in Sel.
  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
  logic [3:0]              wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]       data_out_q, data_out_d;
  logic                    data_oe_q, data_oe_d;
  logic                    ready_q, ready_d;
  logic                    sel_q, sel_d;
  logic                    is_wr_q, is_wr_d;
  logic                    wr_armed_q, wr_armed_d;
  logic                    mem_we_s;
  logic                    hit_s;
  logic [DATA_W-1:0]       mem [2**DEPTH_LOG2];

  assign hit_s = (AdIn[DATA_W-1:DEPTH_LOG2] == BASE_ADDR[DATA_W-1:DEPTH_LOG2]);

  // Next-state and next-output computation; abort beats re-address beats strobes.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wait_cnt_d = wait_cnt_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    ready_d    = ready_q;
    sel_d      = sel_q;
    is_wr_d    = is_wr_q;
    wr_armed_d = wr_armed_q | nWE;
    mem_we_s   = 1'b0;

    if (nME) begin
      state_d   = S_IDLE;
      data_oe_d = 1'b0;
      ready_d   = 1'b0;
      sel_d     = 1'b0;
    end else if (ALE) begin
      state_d   = S_ADDR;
      addr_d    = AdIn[DEPTH_LOG2-1:0];
      sel_d     = hit_s;
      data_oe_d = 1'b0;
      ready_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_ADDR: begin
          if (sel_q && !nOE && nWE) begin
            is_wr_d    = 1'b0;
            wait_cnt_d = 4'(WAIT_STATES);
            state_d    = S_WAIT;
          end else if (sel_q && nOE && !nWE && wr_armed_q) begin
            is_wr_d    = 1'b1;
            wait_cnt_d = 4'(WAIT_STATES);
            state_d    = S_WAIT;
          end else begin
            state_d = S_ADDR;
          end
        end
        S_WAIT: begin
          if (wait_cnt_q != 4'd0) begin
            wait_cnt_d = wait_cnt_q - 4'd1;
          end else if (is_wr_q) begin
            mem_we_s   = 1'b1;
            wr_armed_d = 1'b0;
            ready_d    = 1'b1;
            state_d    = S_WDONE;
          end else begin
            data_out_d = mem[addr_q];
            data_oe_d  = 1'b1;
            ready_d    = 1'b1;
            state_d    = S_RDRIVE;
          end
        end
        S_RDRIVE: begin
          if (nOE) begin
            data_oe_d = 1'b0;
            ready_d   = 1'b0;
            state_d   = S_ADDR;
            if (AUTOINC) begin
              addr_d = addr_q + DEPTH_LOG2'(1);
            end else begin
              addr_d = addr_q;
            end
          end else begin
            state_d = S_RDRIVE;
          end
        end
        S_WDONE: begin
          ready_d = 1'b0;
          state_d = S_ADDR;
          if (AUTOINC) begin
            addr_d = addr_q + DEPTH_LOG2'(1);
          end else begin
            addr_d = addr_q;
          end
        end
        default: begin
          state_d   = S_IDLE;
          data_oe_d = 1'b0;
          ready_d   = 1'b0;
          sel_d     = 1'b0;
        end
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wait_cnt_q <= 4'd0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      ready_q    <= 1'b0;
      sel_q      <= 1'b0;
      is_wr_q    <= 1'b0;
      wr_armed_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wait_cnt_q <= wait_cnt_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      ready_q    <= ready_d;
      sel_q      <= sel_d;
      is_wr_q    <= is_wr_d;
      wr_armed_q <= wr_armed_d;
    end
  end

  // Word array; contents survive reset.
  always_ff @(posedge Clock) begin
    if (mem_we_s) begin
      mem[addr_q] <= AdIn;
    end
  end

  assign DataOut = data_out_q;
  assign DataOe  = data_oe_q;
  assign Ready   = ready_q;
  assign Sel     = sel_q;

endmodule

// File: doc/sysbus_mem_responder.md
Name: sysbus_mem_responder

Overview:
- Memory-side responder on the multiplexed system bus. The core control unit is the initiator on this bus: it drives ALE, nME, nOE and nWE, and shares the address/data lines.
- The block latches the address on ALE and decodes it against its base address.
- It services reads and writes to an internal word array with a programmable number of wait states, and signals completion to the initiator on Ready.
- It sits between the pad-side system bus and the on-chip/behavioural memory model.

Parameters:
- DATA_W, 16, width of a bus word and of the address/data lines.
- DEPTH_LOG2, 8, log2 of the number of words in the array.
- BASE_ADDR, 16'h0000, first word address served; must be aligned to 2**DEPTH_LOG2.
- WAIT_STATES, 1, clock cycles inserted between command detection and data valid / write commit; range 0..15.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- nReset  input  1  reset; asynchronous, active-low.
- AdIn  input  DATA_W  multiplexed address/data from the bus.
- ALE  input  1  address latch enable, active-high.
- nME  input  1  memory enable, active-low.
- nOE  input  1  output enable (read strobe), active-low.
- nWE  input  1  write enable (write strobe), active-low.
- DataOut  output  DATA_W  read data.
- DataOe  output  1  DataOut is driven onto the bus this cycle (pad enable).
- Ready  output  1  access complete: read data valid, or write committed.
- Sel  output  1  latched address falls in [BASE_ADDR, BASE_ADDR + 2**DEPTH_LOG2).

Behaviour:
- Reset (nReset low, asynchronous):
  - state goes to IDLE; AddrReg, WaitCnt, DataOut, DataOe, Ready and Sel all go to 0.
  - Array contents are not reset.
- States: IDLE, ADDR, WAIT, RDRIVE, WDONE. All outputs are registered.
- IDLE:
  - If ALE=1 and nME=0, latch AdIn into AddrReg, set Sel from the decode, and go to ADDR.
  - Otherwise stay in IDLE.
- ADDR:
  - If Sel=0, stay here with no response; DataOe=0 and Ready=0 at all times.
  - If Sel=1 and exactly one of nOE/nWE is low, load WaitCnt=WAIT_STATES and go to WAIT. Record the direction: read if nOE is low, write if nWE is low.
  - If nOE and nWE are both low, treat it as a protocol violation: no action, remain in ADDR.
- WAIT:
  - Decrement WaitCnt each cycle.
  - When WaitCnt=0:
    - read: DataOut=mem[AddrReg[DEPTH_LOG2-1:0]], DataOe=1, Ready=1, go to RDRIVE.
    - write: mem[index] gets AdIn sampled on that same edge, Ready=1, go to WDONE.
  - WAIT_STATES=0 means WAIT lasts exactly one cycle.
  - Latency from the edge that samples the strobe low to Ready=1 is WAIT_STATES+1 cycles.
- RDRIVE:
  - Hold DataOe=1, Ready=1 and DataOut while nOE=0.
  - On the first edge that samples nOE=1, clear DataOe and Ready and return to ADDR. This allows a further access to the same address without a new ALE.
- WDONE:
  - Ready=1 for exactly one cycle, then clear it and return to ADDR.
  - The write commits once per strobe: a new write requires nWE to be sampled high then low again.
  - In ADDR, a write strobe is accepted only after nWE has been sampled high at least once since the last commit.
- Abort (any state): nME sampled high clears DataOe, Ready and Sel on that edge and goes to IDLE. No write commits on that edge.
- Re-address (any state except IDLE): ALE=1 with nME=0 relatches AddrReg and Sel, clears DataOe and Ready, and goes to ADDR. This takes priority over strobe handling on the same edge.
- Priority on a single edge: reset > nME high > ALE > strobe handling.
- Address decode:
  - Sel = (AdIn[DATA_W-1:DEPTH_LOG2] == BASE_ADDR[DATA_W-1:DEPTH_LOG2]).
  - The index is the low DEPTH_LOG2 bits; no out-of-range wrap is ever served.

Optional Feature:
- Macro: SYSBUS_AUTOINC_EN.
- Defined:
  - After each completed access (exit from RDRIVE or WDONE to ADDR), AddrReg increments by 1.
  - The index wraps modulo 2**DEPTH_LOG2 within the served window, and Sel is held.
  - Consecutive strobes without ALE therefore access sequential words.
- Undefined: AddrReg changes only on ALE.

Test Plan:
- Reset mid-read (nReset low while in RDRIVE) -> DataOe=0, Ready=0 and Sel=0 immediately, without a clock edge; after release the block is in IDLE; a preloaded mem[3]=16'hBEEF still reads back 16'hBEEF.
- WAIT_STATES=1, ALE with AdIn=16'h0005, then write strobe with AdIn=16'h1234 -> Ready=1 two cycles after nWE is sampled low, for one cycle; then a read of 16'h0005 returns DataOut=16'h1234 with DataOe=1 two cycles after nOE is sampled low.
- ALE with AdIn=16'h0100 (DEPTH_LOG2=8, BASE_ADDR=0) followed by a read -> Sel=0; DataOe and Ready stay 0 for 10 cycles.
- Read in progress, nME raised during WAIT -> next edge gives IDLE, DataOe=0, Ready=0; a write aborted the same way leaves the array unchanged.
- nOE and nWE both low after a valid ALE -> state stays ADDR, no Ready, array unchanged. ALE on the same edge as a strobe -> address relatched, strobe ignored that cycle.
- SYSBUS_AUTOINC_EN defined: ALE at 16'h00FF, then two read strobes -> mem[255] then mem[0]. Undefined -> mem[255] twice.
